// File: rtl/wash_pkg.sv
// Shared wash-controller definitions: phase codes, fault causes and monitor FSM states.
package wash_pkg;

  localparam logic [2:0] ST_START  = 3'b000;
  localparam logic [2:0] ST_WASH   = 3'b001;
  localparam logic [2:0] ST_SPIN   = 3'b010;
  localparam logic [2:0] ST_DRY    = 3'b011;
  localparam logic [2:0] ST_FINISH = 3'b100;
  localparam logic [2:0] ST_HALT   = 3'b101;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_CODE    = 2'b01;
  localparam logic [1:0] FLT_TRANS   = 2'b10;
  localparam logic [1:0] FLT_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StTrack,
    StFault
  } mon_state_e;

  function automatic logic [5:0] code_onehot(input logic [2:0] code);
    code_onehot = 6'b000001 << code;
  endfunction

endpackage

// File: rtl/wash_trans_check.sv
// Combinational legality check of one phase-code step (prev_op -> operation).
module wash_trans_check
  import wash_pkg::*;
(
  input  logic [2:0] prev_op,
  input  logic [2:0] operation,
  output logic       legal,
  output logic       illegal_code
);

  logic step_ok;

  always_comb begin
    illegal_code = (operation == 3'b110) || (operation == 3'b111);
    step_ok      = 1'b0;
    case (prev_op)
      ST_START:  step_ok = (operation == ST_WASH);
      ST_WASH:   step_ok = (operation == ST_SPIN);
      ST_SPIN:   step_ok = (operation == ST_DRY);
      ST_DRY:    step_ok = (operation == ST_FINISH);
      ST_FINISH: step_ok = (operation == ST_START);
      ST_HALT:   step_ok = (operation == ST_START);
      default:   step_ok = 1'b0;
    endcase
    // Holding a code and entering halt are always acceptable.
    legal = !illegal_code && ((operation == prev_op) || (operation == ST_HALT) || step_ok);
  end

endmodule

// File: rtl/wash_seq_monitor.sv
// Watches the wash controller phase code: tracks dwell, counts completed cycles and
// latches the first fault cause until reset.
module wash_seq_monitor
  import wash_pkg::*;
#(
  parameter int unsigned MAX_DWELL = 40,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       operation,
  output logic [5:0]       phase_onehot,
  output logic [CNT_W-1:0] dwell,
  output logic             cycle_done,
  output logic [CNT_W-1:0] cycles,
  output logic             fault,
  output logic [1:0]       fault_code
);

  mon_state_e       state_q, state_d;
  logic [2:0]       prev_op_q;
  logic [5:0]       phase_q, phase_d;
  logic [CNT_W-1:0] dwell_q, dwell_d, dwell_next;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [1:0]       fault_code_q, fault_code_d;

  logic legal, illegal_code;
  logic held, accept_ok, timeout, completes;

  wash_trans_check u_trans_check (
    .prev_op      (prev_op_q),
    .operation    (operation),
    .legal        (legal),
    .illegal_code (illegal_code)
  );

  always_comb begin
    held       = (state_q == StTrack) && (operation == prev_op_q);
    dwell_next = held ? ((&dwell_q) ? dwell_q : dwell_q + 1'b1) : {{(CNT_W-1){1'b0}}, 1'b1};
    timeout    = (32'(dwell_next) == MAX_DWELL) &&
                 (operation != ST_FINISH) && (operation != ST_HALT);
    completes  = (state_q == StTrack) && (prev_op_q == ST_FINISH) && (operation == ST_START);
    accept_ok  = 1'b0;
    if (state_q == StIdle) begin
      accept_ok = (operation == ST_START) || (operation == ST_HALT);
    end else if (state_q == StTrack) begin
      accept_ok = legal;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    dwell_d      = dwell_q;
    done_d       = 1'b0;
    cycles_d     = cycles_q;
    fault_code_d = fault_code_q;

    unique case (state_q)
      StIdle, StTrack: begin
        // Cause priority: illegal code, then illegal step, then timeout.
        if (illegal_code) begin
          state_d      = StFault;
          fault_code_d = FLT_CODE;
        end else if (!accept_ok) begin
          state_d      = StFault;
          fault_code_d = FLT_TRANS;
        end else if (timeout) begin
          state_d      = StFault;
          fault_code_d = FLT_TIMEOUT;
          dwell_d      = dwell_next;
        end else begin
          state_d = StTrack;
          dwell_d = dwell_next;
          phase_d = code_onehot(operation);
          if (completes) begin
            done_d   = 1'b1;
            cycles_d = cycles_q + 1'b1;
          end
        end
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      prev_op_q    <= ST_START;
      phase_q      <= '0;
      dwell_q      <= '0;
      done_q       <= 1'b0;
      cycles_q     <= '0;
      fault_code_q <= FLT_NONE;
    end else begin
      state_q      <= state_d;
      prev_op_q    <= operation;
      phase_q      <= phase_d;
      dwell_q      <= dwell_d;
      done_q       <= done_d;
      cycles_q     <= cycles_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign phase_onehot = phase_q;
  assign dwell        = dwell_q;
  assign cycle_done   = done_q;
  assign cycles       = cycles_q;
  assign fault        = (state_q == StFault);
  assign fault_code   = fault_code_q;

endmodule

// File: doc/wash_seq_monitor.md
WASH_SEQ_MONITOR -- requirements
Module: wash_seq_monitor

Interface
REQ-001 SHALL have parameter MAX_DWELL, default 8'd40, the maximum cycles any single phase code may persist before a timeout.
REQ-002 SHALL have parameter CNT_W, default 8, the width of the dwell and cycle counters.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-005 SHALL have port operation, input, 3, the phase code from the wash controller: 000 started, 001 washing, 010 spinning, 011 drying, 100 finished, 101 halt.
REQ-006 SHALL have port phase_onehot, output, 6, registered one-hot decode of the last accepted code; bit n corresponds to code n.
REQ-007 SHALL have port dwell, output, CNT_W, the number of consecutive cycles the current code has been held.
REQ-008 SHALL have port cycle_done, output, 1, a one-cycle pulse on each legal 100->000 transition.
REQ-009 SHALL have port cycles, output, CNT_W, the count of completed wash cycles.
REQ-010 SHALL have port fault, output, 1, sticky fault flag.
REQ-011 SHALL have port fault_code, output, 2, the fault cause: 00 none, 01 illegal code (110/111), 10 illegal transition, 11 dwell timeout.

Function
REQ-012 SHALL sample operation every clk edge into prev_op; a transition is operation != prev_op.
REQ-013 SHALL implement FSM states IDLE (no code sampled since reset), TRACK and FAULT.
REQ-014 SHALL, in IDLE, accept only 000 or 101 and move to TRACK; any other value moves to FAULT with code 10, or code 01 for 110/111.
REQ-015 SHALL, in TRACK, treat the transitions 000->001, 001->010, 010->011, 011->100, 100->000, any->101 and 101->000 as legal.
REQ-016 SHALL, in TRACK, treat a held code (no transition) as legal.
REQ-017 SHALL, in TRACK, move to FAULT on any other transition, recording code 10.
REQ-018 SHALL move to FAULT with code 01 when operation is 110 or 111 in any non-FAULT state; this check takes priority over the transition check.
REQ-019 SHALL set dwell to 1 on a legal transition and increment it while the code is held, saturating at all-ones.
REQ-020 SHALL move to FAULT with code 11 when dwell reaches MAX_DWELL and the code is neither 100 nor 101; finished and halt are exempt from timeout.
REQ-021 SHALL assert cycle_done for exactly one cycle, in the cycle after the 100->000 edge is sampled.
REQ-022 SHALL increment cycles on the same edge as cycle_done and wrap from all-ones to 0.
REQ-023 SHALL have fault asserted in FAULT; FAULT is exited only by reset.
REQ-024 SHALL, in FAULT, freeze dwell, cycles, phase_onehot and fault_code.
REQ-025 SHALL record only the highest-priority cause when several faults occur in the same cycle: 01 over 10 over 11.
REQ-026 SHALL update phase_onehot with one-cycle latency from operation on legal codes only.
REQ-027 SHALL hold phase_onehot at 000000 in IDLE.

Reset
REQ-028 SHALL, while rst is low at a clk edge, force: state IDLE, prev_op 000, phase_onehot 0, dwell 0, cycle_done 0, cycles 0, fault 0, fault_code 00.
REQ-029 SHALL treat reset asserted mid-cycle-sequence (e.g. during 010) as a full restart, so that the next code must satisfy the IDLE rules.
REQ-030 SHALL give reset priority over all fault and counter updates in the same cycle.

Structure
REQ-031 SHALL place the phase code constants (ST_START..ST_HALT) and fault code constants in shared package wash_pkg, which is also used by the controller.
REQ-032 SHALL contain one sub-module, wash_trans_check, which is combinational: inputs prev_op and operation; outputs legal, illegal_code.

Verification
REQ-033 SHALL cover a legal sequence: 000 x3, 001 x10, 010 x5, 011 x8, 100 x2, 000 -> cycle_done pulses once, cycles=1, fault=0, and dwell=8 at the end of drying.
REQ-034 SHALL cover an illegal transition: 000 then 001 then 011 -> fault=1 and fault_code=10 one cycle later, with outputs frozen through a further 20 cycles.
REQ-035 SHALL cover an illegal code: drive 110 during washing -> fault_code=01 and phase_onehot stays 000010.
REQ-036 SHALL cover timeout: with MAX_DWELL=40, hold 001 for 40 cycles -> fault_code=11; holding 101 for 100 cycles gives no fault.
REQ-037 SHALL cover reset mid-operation: rst low for 1 cycle during 010 -> all outputs return to reset values; a subsequent 001 gives fault_code=10, while a subsequent 000 is accepted.
REQ-038 SHALL cover wrap: with CNT_W=4, run 16 full cycles -> cycles wraps to 0 with 16 cycle_done pulses.
